ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx_if.sv | 24 ++
 rtl/ps2_host_tx.sv | 188 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Host-to-device PS/2 command channel: byte handshake, status flags and
// the raw/open-drain PS/2 line pins.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic       busy;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;

  modport master (
    output tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
    input  tx_ready, tx_done, tx_error, busy, ps2_clk_oe, ps2_dat_oe
  );

  modport slave (
    input  tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
    output tx_ready, tx_done, tx_error, busy, ps2_clk_oe, ps2_dat_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a start bit,
// then shifts a command byte out on device clock falling edges and checks the ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES     = 5000,
  parameter int unsigned START_SETUP_CYCLES = 50,
  parameter int unsigned TIMEOUT_CYCLES     = 100000
) (
  input logic         clk,
  input logic         reset,
  ps2_host_tx_if.slave bus
);

  localparam int unsigned PH_MAX = (INHIBIT_CYCLES > START_SETUP_CYCLES) ?
                                   INHIBIT_CYCLES : START_SETUP_CYCLES;
  localparam int unsigned CW     = $clog2(PH_MAX + 1);
  localparam int unsigned TW     = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_START, S_DATA, S_PARITY,
    S_STOP, S_ACK, S_RELEASE, S_FINISH
  } state_t;

  state_t          r_state, w_state;
  logic            r_c_s1, r_c_s2, r_c_prev;
  logic            r_d_s1, r_d_s2;
  logic [7:0]      r_shift, w_shift;
  logic            r_parity, w_parity;
  logic [2:0]      r_idx, w_idx;
  logic            r_err, w_err;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [TW-1:0]   r_to_cnt, w_to_cnt;
  logic            r_clk_oe, w_clk_oe;
  logic            r_dat_oe, w_dat_oe;
  logic            w_fe;
  logic            w_in_xfer;
  logic            w_timeout;

  assign w_fe      = r_c_prev & ~r_c_s2;
  assign w_in_xfer = (r_state == S_DATA)  || (r_state == S_PARITY) ||
                     (r_state == S_STOP)  || (r_state == S_ACK)    ||
                     (r_state == S_RELEASE);
  // A device edge in the same cycle as expiry counts as progress, not a timeout.
  assign w_timeout = w_in_xfer && !w_fe && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_c_s1   <= 1'b1;
      r_c_s2   <= 1'b1;
      r_c_prev <= 1'b1;
      r_d_s1   <= 1'b1;
      r_d_s2   <= 1'b1;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_idx    <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_to_cnt <= '0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_c_s1   <= bus.ps2_clk_in;
      r_c_s2   <= r_c_s1;
      r_c_prev <= r_c_s2;
      r_d_s1   <= bus.ps2_dat_in;
      r_d_s2   <= r_d_s1;
      r_shift  <= w_shift;
      r_parity <= w_parity;
      r_idx    <= w_idx;
      r_err    <= w_err;
      r_cnt    <= w_cnt;
      r_to_cnt <= w_to_cnt;
      r_clk_oe <= w_clk_oe;
      r_dat_oe <= w_dat_oe;
    end
  end

  // Line drives are computed for the next state so the pins come straight from flops.
  always_comb begin
    w_state  = r_state;
    w_shift  = r_shift;
    w_parity = r_parity;
    w_idx    = r_idx;
    w_err    = r_err;
    w_cnt    = r_cnt;
    w_to_cnt = '0;
    w_clk_oe = 1'b0;
    w_dat_oe = r_dat_oe;

    if (w_in_xfer)
      w_to_cnt = w_fe ? '0 : r_to_cnt + TW'(1);

    unique case (r_state)
      S_IDLE: begin
        w_dat_oe = 1'b0;
        if (bus.tx_valid) begin
          w_shift  = bus.tx_data;
          w_parity = ~^bus.tx_data;
          w_err    = 1'b0;
          w_cnt    = '0;
          w_clk_oe = 1'b1;
          w_state  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        w_clk_oe = 1'b1;
        w_dat_oe = 1'b0;
        if (r_cnt == CW'(INHIBIT_CYCLES - 1)) begin
          w_cnt    = '0;
          w_dat_oe = 1'b1;
          w_state  = S_START;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_START: begin
        w_clk_oe = 1'b1;
        w_dat_oe = 1'b1;
        if (r_cnt == CW'(START_SETUP_CYCLES - 1)) begin
          w_cnt    = '0;
          w_clk_oe = 1'b0;
          w_idx    = '0;
          w_to_cnt = '0;
          w_state  = S_DATA;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (w_fe) begin
          w_dat_oe = ~r_shift[0];
          w_shift  = {1'b0, r_shift[7:1]};
          w_idx    = r_idx + 3'd1;
          if (r_idx == 3'd7)
            w_state = S_PARITY;
        end
      end
      S_PARITY: begin
        if (w_fe) begin
          w_dat_oe = ~r_parity;
          w_state  = S_STOP;
        end
      end
      S_STOP: begin
        if (w_fe) begin
          w_dat_oe = 1'b0;
          w_state  = S_ACK;
        end
      end
      S_ACK: begin
        w_dat_oe = 1'b0;
        if (w_fe) begin
          w_err   = r_d_s2;
          w_state = S_RELEASE;
        end
      end
      S_RELEASE: begin
        w_dat_oe = 1'b0;
        if (r_c_s2 && r_d_s2)
          w_state = S_FINISH;
      end
      S_FINISH: begin
        w_dat_oe = 1'b0;
        w_state  = S_IDLE;
      end
      default: begin
        w_dat_oe = 1'b0;
        w_state  = S_IDLE;
      end
    endcase

    if (w_timeout) begin
      w_err    = 1'b1;
      w_clk_oe = 1'b0;
      w_dat_oe = 1'b0;
      w_state  = S_FINISH;
    end
  end

  assign bus.tx_ready   = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.tx_done    = (r_state == S_FINISH);
  assign bus.tx_error   = (r_state == S_FINISH) & r_err;
  assign bus.ps2_clk_oe = r_clk_oe;
  assign bus.ps2_dat_oe = r_dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboarded bench: a modelled PS/2 device clocks the host frame while a
// monitor compares each tx_done against the expected outcome queue.
module tb_ps2_host_tx;
  localparam int unsigned INH   = 20;
  localparam int unsigned SETUP = 4;
  localparam int unsigned TO    = 200;
  localparam int unsigned HALF  = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps2_host_tx_if bus();

  ps2_host_tx #(
    .INHIBIT_CYCLES    (INH),
    .START_SETUP_CYCLES(SETUP),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Open-drain wired-AND of device drive and host pull-down.
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  assign bus.ps2_clk_in = dev_clk & ~bus.ps2_clk_oe;
  assign bus.ps2_dat_in = dev_dat & ~bus.ps2_dat_oe;

  typedef struct {
    logic [10:0] frame;
    logic        err;
    bit          chk_frame;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int unsigned t_last_fe = 0;
  int unsigned t_done = 0;
  int unsigned n_done = 0;
  logic [10:0] obs_frame = '0;
  bit          chk_ready_next = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame as the device sees it: start, LSB-first data, odd parity, stop.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    int ones = 0;
    logic [10:0] f;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    f[0]   = 1'b0;
    f[8:1] = d;
    f[9]   = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    f[10]  = 1'b1;
    return f;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (chk_ready_next) begin
      chk_ready_next = 1'b0;
      check("ready_after_done", 32'(bus.tx_ready), 32'd1);
    end
    if (!reset && bus.tx_done) begin
      n_done++;
      t_done = cyc;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got tx_done=1, expected no pending transfer");
      end else begin
        e = sb.pop_front();
        check("tx_error", 32'(bus.tx_error), 32'(e.err));
        if (e.chk_frame) check("frame", 32'(obs_frame), 32'(e.frame));
        check("oe_at_done", 32'({bus.ps2_clk_oe, bus.ps2_dat_oe}), 32'd0);
        check("ready_at_done", 32'(bus.tx_ready), 32'd0);
        chk_ready_next = 1'b1;
      end
    end
  end

  // Device: waits for request-to-send, then produces nfe falling edges.
  task automatic device(input int unsigned nfe, input bit ack, input logic [7:0] junk);
    int unsigned inh = 0, st = 0, guard = 0;
    while (guard < 200) begin
      if (bus.ps2_clk_in === 1'b1 && bus.ps2_dat_in === 1'b0 && bus.busy === 1'b1) break;
      if (bus.ps2_clk_oe && !bus.ps2_dat_oe) inh++;
      if (bus.ps2_clk_oe && bus.ps2_dat_oe) st++;
      if (guard == 3) begin bus.tx_data = junk; bus.tx_valid = 1'b1; end
      if (guard == 6) bus.tx_valid = 1'b0;
      @(negedge clk);
      guard++;
    end
    bus.tx_valid = 1'b0;
    if (guard >= 200) begin
      n_vec++; n_err++;
      $display("FAIL rts_wait: got no request-to-send, expected one within 200 cycles");
      return;
    end
    check("inhibit_cycles", inh, INH);
    check("start_cycles", st, SETUP);
    obs_frame[0] = bus.ps2_dat_in;
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= int'(nfe); k++) begin
      dev_clk = 1'b0;
      if (k == int'(nfe)) t_last_fe = cyc;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (k <= 10) obs_frame[k] = bus.ps2_dat_in;
      if (k == 10 && ack) begin
        repeat (HALF / 2) @(negedge clk);
        dev_dat = 1'b0;
        repeat (HALF - HALF / 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    dev_dat = 1'b1;
  endtask

  task automatic wait_done();
    int unsigned g = 0;
    while (sb.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL done_wait: got no tx_done, expected one within 500 cycles");
      sb.delete();
    end
  endtask

  task automatic send(input logic [7:0] d, input bit ack, input int unsigned nfe, input bit expect_done);
    int unsigned g = 0;
    exp_t e;
    while (bus.tx_ready !== 1'b1 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 1000) begin
      n_vec++; n_err++;
      $display("FAIL ready_wait: got tx_ready=%b, expected 1", bus.tx_ready);
    end
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    if (expect_done) begin
      e.frame     = ref_frame(d);
      e.err       = !(ack && nfe >= 11);
      e.chk_frame = (nfe >= 11);
      sb.push_back(e);
    end
    @(negedge clk);
    bus.tx_valid = 1'b0;
    device(nfe, ack, ~d);
    if (expect_done) wait_done();
  endtask

  initial begin
    int unsigned nd;
    int unsigned lat;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state",
          32'({bus.tx_ready, bus.busy, bus.ps2_clk_oe, bus.ps2_dat_oe, bus.tx_done, bus.tx_error}),
          32'b100000);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    send(8'hED, 1'b1, 11, 1'b1);
    send(8'hF4, 1'b1, 11, 1'b1);
    send(8'hFF, 1'b0, 11, 1'b1);
    send(8'h00, 1'b1, 5, 1'b1);
    lat = t_done - t_last_fe;
    n_vec++;
    if (lat < TO || lat > TO + 10) begin
      n_err++;
      $display("FAIL timeout_latency: got %0d cycles, expected %0d..%0d", lat, TO, TO + 10);
    end

    for (int i = 0; i < 12; i++)
      send(8'($urandom), ($urandom_range(0, 3) != 0), 11, 1'b1);

    // Reset in the middle of the data bits.
    send(8'h5A, 1'b1, 3, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid", 32'({bus.ps2_clk_oe, bus.ps2_dat_oe, bus.tx_ready, bus.busy}), 32'b0010);
    reset = 1'b0;
    nd = n_done;
    repeat (300) @(negedge clk);
    check("no_done_after_reset", n_done, nd);

    send(8'hA5, 1'b1, 11, 1'b1);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish before 50000 cycles");
    $fatal(1);
  end
endmodule
